// File: rtl/fpr_mp_scoreboard.sv
// Multi-port register file with per-register busy scoreboard, write-to-read
// bypass and a post-reset sweep that clears contents one register per cycle.
module fpr_mp_scoreboard #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NWR      = 2,
  parameter int NRD      = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NWR*DW-1:0] wd,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_a,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  output logic [NRD-1:0]    rd_rdy,
  output logic              init_done,
  output logic [AW:0]       busy_cnt
);

  localparam int DEPTH = 2**AW;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    cnt;
  logic [DW-1:0]    rf [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic [NWR-1:0]   we_eff;
  logic             alloc_eff;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [AW:0] popcnt(input logic [DEPTH-1:0] v);
    logic [AW:0] acc;
    acc = '0;
    for (int k = 0; k < DEPTH; k++) acc = acc + {{AW{1'b0}}, v[k]};
    return acc;
  endfunction

  // Writes and allocations only count in RUN and never touch a hardwired r0.
  always_comb begin
    we_eff = '0;
    for (int i = 0; i < NWR; i++)
      we_eff[i] = we[i] && (state == RUN) && !is_zero(wa[i*AW +: AW]);
    alloc_eff = alloc_en && (state == RUN) && !is_zero(alloc_a);
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && (&cnt)) state_nxt = RUN;
  end

  assign init_done = (state == RUN);

  // Allocation is applied after the write clears so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (state == INIT) busy_nxt[cnt] = 1'b0;
    for (int i = 0; i < NWR; i++)
      if (we_eff[i]) busy_nxt[wa[i*AW +: AW]] = 1'b0;
    if (alloc_eff) busy_nxt[alloc_a] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= busy_nxt;
      busy_cnt <= popcnt(busy_nxt);
      if (state == INIT) cnt <= cnt + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  // Contents are untouched by rst itself; the sweep does the clearing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        rf[cnt] <= '0;
      end else begin
        for (int i = 0; i < NWR; i++)
          if (we_eff[i]) rf[wa[i*AW +: AW]] <= wd[i*DW +: DW];
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    logic [DW-1:0] d;

    assign a = ra[j*AW +: AW];

    // Ascending scan so the highest-index matching write port wins.
    always_comb begin
      hit = 1'b0;
      d   = rf[a];
      for (int i = 0; i < NWR; i++) begin
        if (we_eff[i] && (wa[i*AW +: AW] == a)) begin
          hit = 1'b1;
          d   = wd[i*DW +: DW];
        end
      end
    end

    always_comb begin
      rd[j*DW +: DW] = '0;
      rd_rdy[j]      = 1'b0;
      if (state == RUN) begin
        if (is_zero(a)) begin
          rd_rdy[j] = 1'b1;
        end else begin
          rd[j*DW +: DW] = d;
          rd_rdy[j]      = hit || !busy[a];
        end
      end
    end
  end

endmodule
